// File: rtl/rib_wait_bridge_pkg.sv
// Shared bus widths, reset level, state encoding and timeout read-data default
// for the RIB wait-state bridge.
package rib_wait_bridge_pkg;

    localparam int   MEM_ADDR_W = 32;
    localparam int   MEM_W      = 32;
    localparam logic RST_ENABLE = 1'b0;

    localparam logic [MEM_W-1:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rib_wait_bridge.sv
// Stretches a zero-wait RIB slave access into a req/ack device transaction,
// stalling the core via hold_o. Define RIB_WAIT_BRIDGE_TIMEOUT_EN for hung-device timeout.
//
// state | meaning
// IDLE  | no transaction; hold_o follows req_i combinationally
// BUSY  | dev_req_o high with captured request, waiting for dev_ack_i
// DONE  | hold released for one cycle, rdata_o presents the result
module rib_wait_bridge
    import rib_wait_bridge_pkg::*;
#(
    parameter int               TIMEOUT_CYCLES = 255,
    parameter int               CNT_W          = 8,
    parameter logic [MEM_W-1:0] ERR_RDATA      = ERR_RDATA_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [MEM_ADDR_W-1:0] addr_i,
    input  logic [MEM_W-1:0]      wdata_i,
    output logic [MEM_W-1:0]      rdata_o,
    output logic                  hold_o,
    output logic                  dev_req_o,
    output logic                  dev_we_o,
    output logic [MEM_ADDR_W-1:0] dev_addr_o,
    output logic [MEM_W-1:0]      dev_wdata_o,
    input  logic [MEM_W-1:0]      dev_rdata_i,
    input  logic                  dev_ack_i,
    output logic                  err_o
);

    if ((2 ** CNT_W) <= TIMEOUT_CYCLES) begin : g_bad_cnt_w
        $error("CNT_W too narrow for TIMEOUT_CYCLES");
    end

    state_t state_q, state_d;
    logic   timeout_hit;

`ifdef RIB_WAIT_BRIDGE_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            cnt_q <= '0;
        end else if (state_q != ST_BUSY) begin
            cnt_q <= '0;
        end else if (!dev_ack_i && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Ack wins over a coincident timeout.
    assign timeout_hit = (state_q == ST_BUSY) && !dev_ack_i && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            err_q <= 1'b0;
        end else begin
            err_q <= timeout_hit;
        end
    end

    assign err_o = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err_o       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_i) state_d = ST_BUSY;
            ST_BUSY: if (dev_ack_i || timeout_hit) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        hold_o    = 1'b0;
        dev_req_o = 1'b0;
        case (state_q)
            ST_IDLE: hold_o = req_i;
            ST_BUSY: begin
                hold_o    = 1'b1;
                dev_req_o = 1'b1;
            end
            default: ;
        endcase
    end

    // Request is captured only on IDLE->BUSY so req-side changes during BUSY are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            dev_we_o    <= 1'b0;
            dev_addr_o  <= '0;
            dev_wdata_o <= '0;
        end else if ((state_q == ST_IDLE) && req_i) begin
            dev_we_o    <= we_i;
            dev_addr_o  <= addr_i;
            dev_wdata_o <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            rdata_o <= '0;
        end else if ((state_q == ST_BUSY) && !dev_we_o && (dev_ack_i || timeout_hit)) begin
            rdata_o <= dev_ack_i ? dev_rdata_i : ERR_RDATA;
        end
    end

endmodule

// File: tb/tb_rib_wait_bridge.sv
// Self-checking bench for rib_wait_bridge: directed scenarios plus randomized
// traffic against a transaction-level expectation of hold/handshake timing.
module tb_rib_wait_bridge;

    localparam int TB_TIMEOUT = 4;
`ifdef RIB_WAIT_BRIDGE_TIMEOUT_EN
    localparam int MAX_K = TB_TIMEOUT - 1;
    localparam int WR_K  = TB_TIMEOUT - 1;
`else
    localparam int MAX_K = 6;
    localparam int WR_K  = 4;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [31:0] rdata_o;
    logic        hold_o;
    logic        dev_req_o;
    logic        dev_we_o;
    logic [31:0] dev_addr_o;
    logic [31:0] dev_wdata_o;
    logic [31:0] dev_rdata_i = '0;
    logic        dev_ack_i = 1'b0;
    logic        err_o;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_rdata = '0;

    rib_wait_bridge #(
        .TIMEOUT_CYCLES (TB_TIMEOUT),
        .CNT_W          (8),
        .ERR_RDATA      (32'hDEAD_BEEF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .hold_o      (hold_o),
        .dev_req_o   (dev_req_o),
        .dev_we_o    (dev_we_o),
        .dev_addr_o  (dev_addr_o),
        .dev_wdata_o (dev_wdata_o),
        .dev_rdata_i (dev_rdata_i),
        .dev_ack_i   (dev_ack_i),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    // Entered and left at 1 time unit after a rising edge. k = BUSY cycles before the ack
    // cycle; ack = 0 means the device never answers and a timeout completion is expected.
    task automatic run_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input int k, input logic ack, input string nm);
        req_i = 1'b1; we_i = we; addr_i = a; wdata_i = wd;
        dev_ack_i = 1'b0; dev_rdata_i = $urandom;
        #1;
        total++; if (hold_o !== 1'b1) begin bad++; $display("FAIL %s req_hold got=%b exp=1", nm, hold_o); end
        total++; if (dev_req_o !== 1'b0) begin bad++; $display("FAIL %s req_devreq got=%b exp=0", nm, dev_req_o); end
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL %s idle_err got=%b exp=0", nm, err_o); end
        for (int c = 0; c <= k; c++) begin
            @(posedge clk); #1;
            req_i = 1'($urandom); we_i = 1'($urandom); addr_i = $urandom; wdata_i = $urandom;
            dev_ack_i = ack && (c == k);
            dev_rdata_i = dev_ack_i ? rd : $urandom;
            #1;
            total++; if ({hold_o, dev_req_o, dev_we_o} !== {1'b1, 1'b1, we})
                begin bad++; $display("FAIL %s busy%0d hold/req/we got=%b%b%b exp=11%b", nm, c, hold_o, dev_req_o, dev_we_o, we); end
            total++; if (dev_addr_o !== a) begin bad++; $display("FAIL %s busy%0d addr got=%h exp=%h", nm, c, dev_addr_o, a); end
            total++; if (dev_wdata_o !== wd) begin bad++; $display("FAIL %s busy%0d wdata got=%h exp=%h", nm, c, dev_wdata_o, wd); end
            total++; if (rdata_o !== exp_rdata) begin bad++; $display("FAIL %s busy%0d rdata got=%h exp=%h", nm, c, rdata_o, exp_rdata); end
            total++; if (err_o !== 1'b0) begin bad++; $display("FAIL %s busy%0d err got=%b exp=0", nm, c, err_o); end
        end
        @(posedge clk); #1;
        dev_ack_i = 1'b0; dev_rdata_i = $urandom;
        req_i = 1'b1; we_i = we; addr_i = a; wdata_i = wd;
        if (!we) exp_rdata = ack ? rd : 32'hDEAD_BEEF;
        #1;
        total++; if (hold_o !== 1'b0) begin bad++; $display("FAIL %s done_hold got=%b exp=0", nm, hold_o); end
        total++; if (dev_req_o !== 1'b0) begin bad++; $display("FAIL %s done_devreq got=%b exp=0", nm, dev_req_o); end
        total++; if (rdata_o !== exp_rdata) begin bad++; $display("FAIL %s done_rdata got=%h exp=%h", nm, rdata_o, exp_rdata); end
        total++; if (err_o !== !ack) begin bad++; $display("FAIL %s done_err got=%b exp=%b", nm, err_o, !ack); end
        @(posedge clk); #1;
        req_i = 1'b0; dev_ack_i = 1'b0;
    endtask

    // mode 0: quiet, 1: stray ack every cycle, 2: random stray acks
    task automatic idle_gap(input int n, input int mode, input string nm);
        for (int i = 0; i < n; i++) begin
            req_i = 1'b0; we_i = 1'($urandom); addr_i = $urandom; wdata_i = $urandom;
            dev_ack_i = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom) : 1'b0;
            dev_rdata_i = $urandom;
            #1;
            total++; if ({hold_o, dev_req_o} !== 2'b00) begin bad++; $display("FAIL %s idle%0d hold/req got=%b%b exp=00", nm, i, hold_o, dev_req_o); end
            total++; if (rdata_o !== exp_rdata) begin bad++; $display("FAIL %s idle%0d rdata got=%h exp=%h", nm, i, rdata_o, exp_rdata); end
            @(posedge clk); #1;
        end
        dev_ack_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if ({hold_o, dev_req_o, dev_we_o, err_o} !== 4'b0000)
            begin bad++; $display("FAIL reset_ctrl got=%b%b%b%b exp=0000", hold_o, dev_req_o, dev_we_o, err_o); end
        total++; if ({dev_addr_o, dev_wdata_o, rdata_o} !== 96'd0)
            begin bad++; $display("FAIL reset_data got=%h %h %h exp=0", dev_addr_o, dev_wdata_o, rdata_o); end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_read_first_ack();
        run_txn(1'b0, 32'h1000_0004, 32'h0, 32'hA5A5_0001, 0, 1'b1, "read_ack0");
    endtask

    task automatic test_write_wait();
        run_txn(1'b1, 32'h2000_0000, 32'h1234_5678, 32'h5555_AAAA, WR_K, 1'b1, "write_wait");
    endtask

    task automatic test_back_to_back();
        run_txn(1'b0, 32'h3000_0010, 32'h0, 32'h0BAD_F00D, 0, 1'b1, "b2b_first");
        run_txn(1'b0, 32'h3000_0014, 32'h0, 32'hC0FF_EE01, 0, 1'b1, "b2b_second");
    endtask

    task automatic test_stray_ack();
        idle_gap(2, 1, "stray");
        run_txn(1'b0, 32'h4000_0100, 32'h0, 32'h7777_1234, 2, 1'b1, "stray_read");
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            idle_gap($urandom_range(0, 2), 2, "rand_gap");
            run_txn(1'($urandom), $urandom, $urandom, $urandom, $urandom_range(0, MAX_K), 1'b1, "rand_txn");
        end
    endtask

`ifdef RIB_WAIT_BRIDGE_TIMEOUT_EN
    task automatic test_timeout();
        run_txn(1'b0, 32'h5000_0000, 32'h0, 32'h0, TB_TIMEOUT - 1, 1'b0, "to_read");
        run_txn(1'b0, 32'h5000_0004, 32'h0, 32'h1357_9BDF, TB_TIMEOUT - 1, 1'b1, "to_ack_wins");
        run_txn(1'b1, 32'h5000_0008, 32'hFEED_0001, 32'h0, TB_TIMEOUT - 1, 1'b0, "to_write");
        idle_gap(1, 0, "to_after");
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL to_err_clear got=%b exp=0", err_o); end
    endtask
`endif

    task automatic test_reset_mid();
        run_txn(1'b0, 32'h6000_0020, 32'h0, 32'h2468_ACE0, 0, 1'b1, "pre_reset");
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h6000_0024; wdata_i = 32'h9999_0000;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
        end
        #1;
        total++; if ({hold_o, dev_req_o} !== 2'b11) begin bad++; $display("FAIL rst_mid_busy got=%b%b exp=11", hold_o, dev_req_o); end
        rst = 1'b0; req_i = 1'b0;
        #1;
        exp_rdata = '0;
        total++; if ({hold_o, dev_req_o, dev_we_o, err_o} !== 4'b0000)
            begin bad++; $display("FAIL rst_mid_ctrl got=%b%b%b%b exp=0000", hold_o, dev_req_o, dev_we_o, err_o); end
        total++; if ({dev_addr_o, dev_wdata_o, rdata_o} !== 96'd0)
            begin bad++; $display("FAIL rst_mid_data got=%h %h %h exp=0", dev_addr_o, dev_wdata_o, rdata_o); end
        @(posedge clk); #1;
        rst = 1'b1;
        idle_gap(3, 1, "post_reset");
        idle_gap(1, 0, "post_reset_q");
    endtask

    initial begin
        test_reset();
        test_read_first_ack();
        test_write_wait();
        test_back_to_back();
        test_stray_ack();
        test_random();
`ifdef RIB_WAIT_BRIDGE_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
